rom_burst_arbiter: RTL and testbench

Shares one combinational 4-bit lookup ROM read port between two requesters. Each requester asks for a burst of 1 to 4 consecutive words. The block arbitrates round-robin, sequences the ROM address, and returns registered read data with valid and last flags. It sits between the ROM instance and two client engines, such as a pattern generator and a self-checker.

---
 rtl/rom_burst_arbiter.sv | 104 ++++++++++
 tb/tb_rom_burst_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between two
// burst requesters; returns registered data with per-requester valid/last.
module rom_burst_arbiter #(
   parameter int AW   = 4,
   parameter int DW   = 4,
   parameter int LENW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0,
   input  logic [AW-1:0]   addr0,
   input  logic [LENW-1:0] len0,
   output logic            gnt0,
   output logic            rvalid0,
   output logic [DW-1:0]   rdata0,
   output logic            rlast0,
   input  logic            req1,
   input  logic [AW-1:0]   addr1,
   input  logic [LENW-1:0] len1,
   output logic            gnt1,
   output logic            rvalid1,
   output logic [DW-1:0]   rdata1,
   output logic            rlast1,
   output logic [AW-1:0]   rom_addr,
   input  logic [DW-1:0]   rom_data,
   output logic            busy
);

   // Handshake: a requester holds req/addr/len until it sees a one-cycle gnt;
   // beats then arrive on rvalid with no backpressure, rlast marking the final one.
   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_q, state_d;
   logic              owner_q;
   logic              ptr_q;
   logic [AW-1:0]     cur_addr_q;
   logic [LENW-1:0]   cnt_q;

   assign busy = (state_q == BURST);

   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      state_d  = state_q;
      rom_addr = '0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so no grant is shown while reset is held.
            if (rst_n) begin
               if (req0 && (!req1 || !ptr_q)) gnt0 = 1'b1;
               else if (req1)                 gnt1 = 1'b1;
               if (gnt0 || gnt1) state_d = BURST;
            end
         end
         BURST: begin
            rom_addr = cur_addr_q;
            if (cnt_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         ptr_q      <= 1'b0;
         cur_addr_q <= '0;
         cnt_q      <= '0;
         rvalid0    <= 1'b0;
         rlast0     <= 1'b0;
         rdata0     <= '0;
         rvalid1    <= 1'b0;
         rlast1     <= 1'b0;
         rdata1     <= '0;
      end else begin
         state_q <= state_d;
         rvalid0 <= 1'b0;
         rlast0  <= 1'b0;
         rvalid1 <= 1'b0;
         rlast1  <= 1'b0;
         if (gnt0 || gnt1) begin
            owner_q    <= gnt1;
            cur_addr_q <= gnt1 ? addr1 : addr0;
            cnt_q      <= gnt1 ? len1 : len0;
            ptr_q      <= gnt0;
         end
         if (state_q == BURST) begin
            if (owner_q) begin
               rdata1  <= rom_data;
               rvalid1 <= 1'b1;
               rlast1  <= (cnt_q == '0);
            end else begin
               rdata0  <= rom_data;
               rvalid0 <= 1'b1;
               rlast0  <= (cnt_q == '0);
            end
            cur_addr_q <= cur_addr_q + AW'(1);
            cnt_q      <= cnt_q - LENW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: directed scenarios then random traffic, all
// outputs checked each cycle against a scheduled-beat reference model.
module tb_rom_burst_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] addr0 = '0, addr1 = '0;
   logic [1:0] len0 = '0, len1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, busy;
   logic [3:0] rdata0, rdata1, rom_addr, rom_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit tmo    = 1'b0;

   // Reference model: grant rule, busy window and a queue of expected beats
   // {cycle, last, data} per requester, derived from word(a) = 15 - a.
   int          mbusy = 0;
   logic [3:0]  mcur  = '0;
   bit          mptr  = 1'b0;
   logic [3:0]  mdata0 = '0, mdata1 = '0;
   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];

   always #5 clk = ~clk;

   assign rom_data = 4'd15 - rom_addr;

   rom_burst_arbiter #(.AW(4), .DW(4), .LENW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
      .rvalid0(rvalid0), .rdata0(rdata0), .rlast0(rlast0),
      .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
      .rvalid1(rvalid1), .rdata1(rdata1), .rlast1(rlast1),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic push_beats(input bit r, input logic [3:0] a, input logic [1:0] l);
      for (int i = 0; i <= int'(l); i++) begin
         logic [36:0] e;
         e = {32'(cyc + 2 + i), (i == int'(l)), 4'(15 - ((int'(a) + i) % 16))};
         if (r) exp_q1.push_back(e);
         else   exp_q0.push_back(e);
      end
   endtask

   // Per-cycle monitor, sampling on the falling edge.
   always @(negedge clk) begin
      logic        eg0, eg1;
      logic [36:0] e;
      cyc++;
      chk("gnt_wait", 32'(tmo), 32'(0));
      if (!rst_n) begin
         chk("reset_outputs",
             32'({gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, busy, rom_addr, rdata0, rdata1}),
             32'(0));
         mbusy  = 0;
         mptr   = 1'b0;
         mdata0 = '0;
         mdata1 = '0;
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         eg0 = 1'b0;
         eg1 = 1'b0;
         if (mbusy == 0) begin
            if (req0 && (!req1 || !mptr)) eg0 = 1'b1;
            else if (req1)                eg1 = 1'b1;
         end
         chk("gnt0", 32'(gnt0), 32'(eg0));
         chk("gnt1", 32'(gnt1), 32'(eg1));
         chk("busy", 32'(busy), 32'(mbusy != 0));
         chk("rom_addr", 32'(rom_addr), (mbusy != 0) ? 32'(mcur) : 32'(0));

         if (exp_q0.size() > 0 && int'(exp_q0[0][36:5]) == cyc) begin
            e = exp_q0.pop_front();
            chk("rvalid0", 32'(rvalid0), 32'(1));
            chk("rdata0",  32'(rdata0),  32'(e[3:0]));
            chk("rlast0",  32'(rlast0),  32'(e[4]));
            mdata0 = e[3:0];
         end else begin
            chk("rvalid0_idle", 32'(rvalid0), 32'(0));
            chk("rlast0_idle",  32'(rlast0),  32'(0));
            chk("rdata0_hold",  32'(rdata0),  32'(mdata0));
         end
         if (exp_q1.size() > 0 && int'(exp_q1[0][36:5]) == cyc) begin
            e = exp_q1.pop_front();
            chk("rvalid1", 32'(rvalid1), 32'(1));
            chk("rdata1",  32'(rdata1),  32'(e[3:0]));
            chk("rlast1",  32'(rlast1),  32'(e[4]));
            mdata1 = e[3:0];
         end else begin
            chk("rvalid1_idle", 32'(rvalid1), 32'(0));
            chk("rlast1_idle",  32'(rlast1),  32'(0));
            chk("rdata1_hold",  32'(rdata1),  32'(mdata1));
         end

         if (mbusy != 0) begin
            mbusy--;
            mcur = mcur + 4'd1;
         end else if (eg0) begin
            push_beats(1'b0, addr0, len0);
            mbusy = int'(len0) + 1;
            mcur  = addr0;
            mptr  = 1'b1;
         end else if (eg1) begin
            push_beats(1'b1, addr1, len1);
            mbusy = int'(len1) + 1;
            mcur  = addr1;
            mptr  = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Returns one step into the cycle after the grant.
   task automatic wait_gnt(input bit r);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = r ? gnt1 : gnt0;
      end
      if (!got) tmo = 1'b1;
      tick();
   endtask

   initial begin
      bit g0, g1;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // single beat
      req0 = 1'b1; addr0 = 4'd3; len0 = 2'd0;
      wait_gnt(1'b0);
      req0 = 1'b0;
      idle(4);

      // wrapping burst
      req1 = 1'b1; addr1 = 4'd14; len1 = 2'd3;
      wait_gnt(1'b1);
      req1 = 1'b0;
      idle(6);

      // contention and round-robin from a fresh reset
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      req0 = 1'b1; addr0 = 4'd2; len0 = 2'd1;
      req1 = 1'b1; addr1 = 4'd9; len1 = 2'd2;
      wait_gnt(1'b0);
      req0 = 1'b0;
      wait_gnt(1'b1);
      req1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1; addr0 = 4'd6;
      wait_gnt(1'b0);
      req0 = 1'b0; req1 = 1'b0;
      idle(6);
      req0 = 1'b1; req1 = 1'b1; addr1 = 4'd12; len1 = 2'd0;
      wait_gnt(1'b1);
      req1 = 1'b0;
      wait_gnt(1'b0);
      req0 = 1'b0;
      idle(8);

      // reset during a burst, after its second beat
      req0 = 1'b1; addr0 = 4'd0; len0 = 2'd3;
      wait_gnt(1'b0);
      req0 = 1'b0;
      idle(3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle(4);
      req0 = 1'b1; addr0 = 4'd5; len0 = 2'd1;
      wait_gnt(1'b0);
      req0 = 1'b0;
      idle(5);

      // request dropped after grant; addr/len changes are ignored
      req0 = 1'b1; addr0 = 4'd8; len0 = 2'd2;
      wait_gnt(1'b0);
      req0 = 1'b0; addr0 = 4'd1; len0 = 2'd3;
      idle(6);

      // single requester, three back-to-back bursts
      req1 = 1'b1; addr1 = 4'd5; len1 = 2'd1;
      repeat (3) wait_gnt(1'b1);
      req1 = 1'b0;
      idle(6);

      // random traffic with occasional reset pulses
      repeat (400) begin
         @(negedge clk);
         g0 = gnt0;
         g1 = gnt1;
         tick();
         rst_n = ($urandom_range(0, 63) != 0);
         if (!req0 || g0) begin
            req0  = ($urandom_range(0, 2) == 0);
            addr0 = 4'($urandom);
            len0  = 2'($urandom);
         end
         if (!req1 || g1) begin
            req1  = ($urandom_range(0, 2) == 0);
            addr1 = 4'($urandom);
            len1  = 2'($urandom);
         end
      end
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
